// File: rtl/alu_issue.sv
// alu_issue: RV32I integer-ALU decode and issue stage with a single
// registered output slot and valid/ready handshakes on both sides.
// Optional feature: define ALU_ISSUE_AUIPC_EN to decode AUIPC (PC-relative
// add). Without it, AUIPC issues as an illegal instruction.
module alu_issue #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_instr_vld,
  output logic             o_instr_rdy,
  input  logic [31:0]      i_instr,
  input  logic [31:0]      i_pc,
  input  logic [31:0]      i_rs1_data,
  input  logic [31:0]      i_rs2_data,
  output logic             o_iss_vld,
  input  logic             i_iss_rdy,
  output logic [31:0]      o_op_a,
  output logic [31:0]      o_op_b,
  output logic [3:0]       o_alu_op,
  output logic [4:0]       o_rd_addr,
  output logic             o_rd_wen,
  output logic             o_illegal,
  output logic [CNT_W-1:0] o_iss_cnt
);

  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_SLT  = 4'h2,
    ALU_SLTU = 4'h3,
    ALU_XOR  = 4'h4,
    ALU_OR   = 4'h5,
    ALU_AND  = 4'h6,
    ALU_SLL  = 4'h7,
    ALU_SRL  = 4'h8,
    ALU_SRA  = 4'h9,
    ALU_LUI  = 4'hA
  } alu_op_e;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [31:0] imm_i;
  logic [31:0] imm_u;
  logic [31:0] shamt;

  assign opcode = i_instr[6:0];
  assign funct3 = i_instr[14:12];
  assign funct7 = i_instr[31:25];
  assign rd     = i_instr[11:7];
  assign imm_i  = {{20{i_instr[31]}}, i_instr[31:20]};
  assign imm_u  = {i_instr[31:12], 12'b0};
  assign shamt  = {27'b0, i_instr[24:20]};

`ifndef ALU_ISSUE_AUIPC_EN
  logic unused_pc;
  assign unused_pc = ^i_pc;
`endif

  alu_op_e     base_op;
  alu_op_e     dec_op;
  logic [31:0] dec_a;
  logic [31:0] dec_b;
  logic        dec_ill;
  logic        dec_wen;
  logic        load;
  logic        accept;

  // Ready whenever the output slot is empty or is being drained this cycle.
  assign o_instr_rdy = !o_iss_vld | i_iss_rdy;
  assign load        = i_instr_vld & o_instr_rdy;
  assign accept      = o_iss_vld & i_iss_rdy;

  // Map funct3 to the ALU operation shared by OP and OP-IMM (base funct7 variant).
  always_comb begin
    base_op = ALU_ADD;
    case (funct3)
      3'b000:  base_op = ALU_ADD;
      3'b001:  base_op = ALU_SLL;
      3'b010:  base_op = ALU_SLT;
      3'b011:  base_op = ALU_SLTU;
      3'b100:  base_op = ALU_XOR;
      3'b101:  base_op = ALU_SRL;
      3'b110:  base_op = ALU_OR;
      default: base_op = ALU_AND;
    endcase
  end

  // Decode the incoming word into operands, ALU op and legality; illegal words are zeroed.
  always_comb begin
    dec_a   = '0;
    dec_b   = '0;
    dec_op  = ALU_ADD;
    dec_ill = 1'b1;
    case (opcode)
      OPC_OP: begin
        dec_a = i_rs1_data;
        dec_b = i_rs2_data;
        if (funct7 == F7_BASE) begin
          dec_ill = 1'b0;
          dec_op  = base_op;
        end else if (funct7 == F7_ALT) begin
          if (funct3 == 3'b000) begin
            dec_ill = 1'b0;
            dec_op  = ALU_SUB;
          end else if (funct3 == 3'b101) begin
            dec_ill = 1'b0;
            dec_op  = ALU_SRA;
          end
        end
      end
      OPC_IMM: begin
        dec_a   = i_rs1_data;
        dec_b   = imm_i;
        dec_ill = 1'b0;
        dec_op  = base_op;
        if (funct3 == 3'b001) begin
          dec_b   = shamt;
          dec_ill = (funct7 != F7_BASE);
        end else if (funct3 == 3'b101) begin
          dec_b = shamt;
          if (funct7 == F7_ALT) begin
            dec_op = ALU_SRA;
          end else if (funct7 != F7_BASE) begin
            dec_ill = 1'b1;
          end
        end
      end
      OPC_LUI: begin
        dec_a   = '0;
        dec_b   = imm_u;
        dec_op  = ALU_LUI;
        dec_ill = 1'b0;
      end
`ifdef ALU_ISSUE_AUIPC_EN
      OPC_AUIPC: begin
        dec_a   = i_pc;
        dec_b   = imm_u;
        dec_op  = ALU_ADD;
        dec_ill = 1'b0;
      end
`endif
      default: dec_ill = 1'b1;
    endcase
    if (dec_ill) begin
      dec_a  = '0;
      dec_b  = '0;
      dec_op = ALU_ADD;
    end
  end

  assign dec_wen = !dec_ill && (rd != 5'd0);

  // Output slot: load on input handshake, drop valid on accept with no refill.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_iss_vld <= 1'b0;
      o_op_a    <= '0;
      o_op_b    <= '0;
      o_alu_op  <= '0;
      o_rd_addr <= '0;
      o_rd_wen  <= 1'b0;
      o_illegal <= 1'b0;
    end else if (load) begin
      o_iss_vld <= 1'b1;
      o_op_a    <= dec_a;
      o_op_b    <= dec_b;
      o_alu_op  <= dec_op;
      o_rd_addr <= rd;
      o_rd_wen  <= dec_wen;
      o_illegal <= dec_ill;
    end else if (accept) begin
      o_iss_vld <= 1'b0;
    end
  end

  // Count completed downstream handshakes, wrapping naturally.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_iss_cnt <= '0;
    end else if (accept) begin
      o_iss_cnt <= o_iss_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: table-driven checks of alu_issue decode plus hand-written
// stall, back-to-back, and mid-handshake reset sequences.
module tb_alu_issue;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             instr_vld;
  logic             instr_rdy;
  logic [31:0]      instr;
  logic [31:0]      pc;
  logic [31:0]      rs1_data;
  logic [31:0]      rs2_data;
  logic             iss_vld;
  logic             iss_rdy;
  logic [31:0]      op_a;
  logic [31:0]      op_b;
  logic [3:0]       alu_op;
  logic [4:0]       rd_addr;
  logic             rd_wen;
  logic             illegal;
  logic [CNT_W-1:0] iss_cnt;

  int checks;
  int failures;
  logic [CNT_W-1:0] exp_cnt;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        wen;
    logic        ill;
  } vec_t;

  vec_t vecs[$];

  alu_issue #(.CNT_W(CNT_W)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_instr_vld (instr_vld),
    .o_instr_rdy (instr_rdy),
    .i_instr     (instr),
    .i_pc        (pc),
    .i_rs1_data  (rs1_data),
    .i_rs2_data  (rs2_data),
    .o_iss_vld   (iss_vld),
    .i_iss_rdy   (iss_rdy),
    .o_op_a      (op_a),
    .o_op_b      (op_b),
    .o_alu_op    (alu_op),
    .o_rd_addr   (rd_addr),
    .o_rd_wen    (rd_wen),
    .o_illegal   (illegal),
    .o_iss_cnt   (iss_cnt)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void addVec(string n, logic [31:0] i, logic [31:0] p,
                                 logic [31:0] r1, logic [31:0] r2,
                                 logic [31:0] a, logic [31:0] b, logic [3:0] op,
                                 logic [4:0] rd, logic wen, logic ill);
    vec_t v;
    v.name = n; v.instr = i; v.pc = p; v.rs1 = r1; v.rs2 = r2;
    v.a = a; v.b = b; v.op = op; v.rd = rd; v.wen = wen; v.ill = ill;
    vecs.push_back(v);
  endfunction

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkVec(vec_t v);
    checkOutput({v.name, ".op_a"},    op_a, v.a);
    checkOutput({v.name, ".op_b"},    op_b, v.b);
    checkOutput({v.name, ".alu_op"},  32'(alu_op), 32'(v.op));
    checkOutput({v.name, ".rd_wen"},  32'(rd_wen), 32'(v.wen));
    checkOutput({v.name, ".illegal"}, 32'(illegal), 32'(v.ill));
    if (!v.ill) checkOutput({v.name, ".rd_addr"}, 32'(rd_addr), 32'(v.rd));
  endtask

  task automatic applyStimulus(vec_t v, logic rdy);
    instr     = v.instr;
    pc        = v.pc;
    rs1_data  = v.rs1;
    rs2_data  = v.rs2;
    instr_vld = 1'b1;
    iss_rdy   = rdy;
  endtask

  task automatic checkAllZero(string tag);
    checkOutput({tag, ".iss_vld"},   32'(iss_vld), 32'd0);
    checkOutput({tag, ".op_a"},      op_a, 32'd0);
    checkOutput({tag, ".op_b"},      op_b, 32'd0);
    checkOutput({tag, ".alu_op"},    32'(alu_op), 32'd0);
    checkOutput({tag, ".rd_addr"},   32'(rd_addr), 32'd0);
    checkOutput({tag, ".rd_wen"},    32'(rd_wen), 32'd0);
    checkOutput({tag, ".illegal"},   32'(illegal), 32'd0);
    checkOutput({tag, ".iss_cnt"},   32'(iss_cnt), 32'd0);
    checkOutput({tag, ".instr_rdy"}, 32'(instr_rdy), 32'd1);
  endtask

  // Main directed test sequence.
  initial begin
    checks    = 0;
    failures  = 0;
    exp_cnt   = '0;
    rst_n     = 1'b0;
    instr_vld = 1'b0;
    instr     = '0;
    pc        = '0;
    rs1_data  = '0;
    rs2_data  = '0;
    iss_rdy   = 1'b0;

    addVec("add",      32'h002081B3, 0, 5, 7, 5, 7, 4'h0, 3, 1, 0);
    addVec("sub",      32'h402081B3, 0, 5, 7, 5, 7, 4'h1, 3, 1, 0);
    addVec("srai",     32'h40335293, 0, 32'h80000000, 0, 32'h80000000, 3, 4'h9, 5, 1, 0);
    addVec("lui",      32'h123450B7, 0, 32'h55, 32'h66, 0, 32'h12345000, 4'hA, 1, 1, 0);
    addVec("lui_rd0",  32'h12345037, 0, 0, 0, 0, 32'h12345000, 4'hA, 0, 0, 0);
`ifdef ALU_ISSUE_AUIPC_EN
    addVec("auipc",    32'h00001117, 32'h100, 9, 9, 32'h100, 32'h1000, 4'h0, 2, 1, 0);
`else
    addVec("auipc",    32'h00001117, 32'h100, 9, 9, 0, 0, 4'h0, 2, 0, 1);
`endif
    addVec("addi_neg", 32'hFFF08213, 0, 32'hA, 0, 32'hA, 32'hFFFFFFFF, 4'h0, 4, 1, 0);
    addVec("slti",     32'hFFE0A113, 0, 1, 0, 1, 32'hFFFFFFFE, 4'h2, 2, 1, 0);
    addVec("slt",      32'h0020A1B3, 0, 1, 2, 1, 2, 4'h2, 3, 1, 0);
    addVec("sltu",     32'h0020B1B3, 0, 1, 2, 1, 2, 4'h3, 3, 1, 0);
    addVec("sll",      32'h002091B3, 0, 1, 2, 1, 2, 4'h7, 3, 1, 0);
    addVec("srl",      32'h0020D1B3, 0, 1, 2, 1, 2, 4'h8, 3, 1, 0);
    addVec("sra",      32'h4020D1B3, 0, 1, 2, 1, 2, 4'h9, 3, 1, 0);
    addVec("xor",      32'h0020C1B3, 0, 1, 2, 1, 2, 4'h4, 3, 1, 0);
    addVec("or",       32'h0020E1B3, 0, 1, 2, 1, 2, 4'h5, 3, 1, 0);
    addVec("and",      32'h0020F1B3, 0, 1, 2, 1, 2, 4'h6, 3, 1, 0);
    addVec("xori",     32'h7FF14313, 0, 3, 0, 3, 32'h7FF, 4'h4, 6, 1, 0);
    addVec("srli",     32'h01F0D393, 0, 32'hF0, 0, 32'hF0, 32'd31, 4'h8, 7, 1, 0);
    addVec("ill_mul",  32'h022081B3, 0, 5, 7, 0, 0, 4'h0, 3, 0, 1);
    addVec("ill_f7",   32'h4020C1B3, 0, 5, 7, 0, 0, 4'h0, 3, 0, 1);
    addVec("ill_slli", 32'h40309293, 0, 5, 7, 0, 0, 4'h0, 5, 0, 1);
    addVec("ill_zero", 32'h00000000, 0, 5, 7, 0, 0, 4'h0, 0, 0, 1);

    // Reset state, during reset and the first cycle after release.
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    rst_n = 1'b1;
    checkOutput("post_reset.instr_rdy", 32'(instr_rdy), 32'd1);
    @(posedge clk);
    #1;

    // Single issues with the consumer always ready.
    for (int k = 0; k < vecs.size(); k++) begin
      applyStimulus(vecs[k], 1'b1);
      @(posedge clk);
      #1;
      instr_vld = 1'b0;
      checkOutput({vecs[k].name, ".iss_vld"}, 32'(iss_vld), 32'd1);
      checkVec(vecs[k]);
      checkOutput({vecs[k].name, ".cnt_before"}, 32'(iss_cnt), 32'(exp_cnt));
      @(posedge clk);
      #1;
      exp_cnt = exp_cnt + 1'b1;
      checkOutput({vecs[k].name, ".cnt_after"}, 32'(iss_cnt), 32'(exp_cnt));
      checkOutput({vecs[k].name, ".drained"}, 32'(iss_vld), 32'd0);
    end

    // Stall: consumer not ready for 3 cycles while a new word waits upstream.
    applyStimulus(vecs[0], 1'b0);
    @(posedge clk);
    #1;
    applyStimulus(vecs[3], 1'b0);
    for (int s = 0; s < 3; s++) begin
      checkOutput("stall.iss_vld", 32'(iss_vld), 32'd1);
      checkOutput("stall.instr_rdy", 32'(instr_rdy), 32'd0);
      checkOutput("stall.cnt", 32'(iss_cnt), 32'(exp_cnt));
      checkVec(vecs[0]);
      @(posedge clk);
      #1;
    end
    iss_rdy = 1'b1;
    #1;
    checkOutput("release.instr_rdy", 32'(instr_rdy), 32'd1);
    @(posedge clk);
    #1;
    exp_cnt = exp_cnt + 1'b1;
    checkOutput("swap.iss_vld", 32'(iss_vld), 32'd1);
    checkOutput("swap.cnt", 32'(iss_cnt), 32'(exp_cnt));
    checkVec(vecs[3]);

    // Back-to-back stream: one issue per cycle with no bubbles.
    for (int k = 1; k < 7; k++) begin
      applyStimulus(vecs[k], 1'b1);
      @(posedge clk);
      #1;
      exp_cnt = exp_cnt + 1'b1;
      checkOutput("stream.iss_vld", 32'(iss_vld), 32'd1);
      checkOutput("stream.cnt", 32'(iss_cnt), 32'(exp_cnt));
      checkVec(vecs[k]);
    end
    instr_vld = 1'b0;
    @(posedge clk);
    #1;
    exp_cnt = exp_cnt + 1'b1;
    checkOutput("stream_end.iss_vld", 32'(iss_vld), 32'd0);
    checkOutput("stream_end.cnt", 32'(iss_cnt), 32'(exp_cnt));

    // Reset asserted while an instruction is held by a stalled consumer.
    applyStimulus(vecs[2], 1'b0);
    @(posedge clk);
    #1;
    instr_vld = 1'b0;
    checkOutput("held.iss_vld", 32'(iss_vld), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("mid_reset");
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    iss_rdy = 1'b1;
    exp_cnt = '0;
    checkOutput("after_reset.instr_rdy", 32'(instr_rdy), 32'd1);
    for (int s = 0; s < 3; s++) begin
      @(posedge clk);
      #1;
      checkOutput("discard.iss_vld", 32'(iss_vld), 32'd0);
      checkOutput("discard.cnt", 32'(iss_cnt), 32'd0);
    end

    // Recovery issue after reset.
    applyStimulus(vecs[0], 1'b1);
    @(posedge clk);
    #1;
    instr_vld = 1'b0;
    checkVec(vecs[0]);
    @(posedge clk);
    #1;
    exp_cnt = exp_cnt + 1'b1;
    checkOutput("recover.cnt", 32'(iss_cnt), 32'(exp_cnt));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have parameter CNT_W, default 16, giving the width of the issue counter.
REQ-002 SHALL have port i_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port i_instr_vld, input, 1, upstream instruction valid.
REQ-005 SHALL have port o_instr_rdy, output, 1, block can accept an instruction.
REQ-006 SHALL have port i_instr, input, 32, RV32I instruction word.
REQ-007 SHALL have port i_pc, input, 32, PC of i_instr.
REQ-008 SHALL have ports i_rs1_data and i_rs2_data, input, 32 each, register-file read data for rs1/rs2.
REQ-009 SHALL have port o_iss_vld, output, 1, ALU operands valid.
REQ-010 SHALL have port i_iss_rdy, input, 1, ALU/writeback stage accepts.
REQ-011 SHALL have ports o_op_a and o_op_b, output, 32 each, ALU operands.
REQ-012 SHALL have port o_alu_op, output, 4; encoding ADD=0 SUB=1 SLT=2 SLTU=3 XOR=4 OR=5 AND=6 SLL=7 SRL=8 SRA=9 LUI=A.
REQ-013 SHALL have ports o_rd_addr (output, 5) and o_rd_wen (output, 1), destination register and write enable.
REQ-014 SHALL have port o_illegal, output, 1, issued word was not a supported instruction.
REQ-015 SHALL have port o_iss_cnt, output, CNT_W, count of completed issue handshakes.

Function
REQ-016 SHALL register all outputs except o_instr_rdy; decode-to-issue latency is exactly 1 cycle.
REQ-017 SHALL drive o_instr_rdy = !o_iss_vld | i_iss_rdy, combinationally.
REQ-018 SHALL load the output register on i_instr_vld & o_instr_rdy, and set o_iss_vld the next cycle.
REQ-019 SHALL clear o_iss_vld after o_iss_vld & i_iss_rdy when no new instruction loads in that cycle; simultaneous accept and load keeps o_iss_vld=1 with the new contents (full throughput, no bubble).
REQ-020 SHALL hold every output stable while o_iss_vld & !i_iss_rdy.
REQ-021 SHALL decode opcode 0110011 (OP) to op_a=rs1, op_b=rs2.
- alu_op from funct3: 000 ADD (funct7 0100000 gives SUB), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL (0100000 gives SRA), 110 OR, 111 AND.
- funct7 other than 0000000/0100000, or 0100000 with funct3 not 000/101, is illegal.
REQ-022 SHALL decode opcode 0010011 (OP-IMM) to op_a=rs1, op_b=sign-extended I-immediate, with alu_op as in REQ-021.
- funct3 000 is never SUB.
- For 001/101, op_b={27'b0,shamt}; funct7 must be 0000000 (SLLI/SRLI) or 0100000 (SRAI only), otherwise illegal.
REQ-023 SHALL decode opcode 0110111 (LUI) to op_a=0, op_b={instr[31:12],12'b0}, alu_op=LUI.
REQ-024 SHALL set o_rd_addr=instr[11:7] and o_rd_wen=1 for legal instructions, but o_rd_wen=0 when rd=0.
REQ-025 SHALL issue an illegal word with o_illegal=1, o_alu_op=ADD, o_op_a=o_op_b=0, o_rd_wen=0; it is still handshaken.
REQ-026 SHALL increment o_iss_cnt by 1 on each o_iss_vld & i_iss_rdy, wrapping from all-ones to 0.

Reset
REQ-027 SHALL, while i_rst_n=0, asynchronously force o_iss_vld=0, o_op_a=0, o_op_b=0, o_alu_op=0, o_rd_addr=0, o_rd_wen=0, o_illegal=0, o_iss_cnt=0.
REQ-028 SHALL discard an instruction pending in the output register when reset asserts mid-handshake; no issue occurs for it after release.
REQ-029 SHALL give o_instr_rdy=1 during reset and in the first cycle after deassertion.

Configuration
REQ-030 SHALL support macro ALU_ISSUE_AUIPC_EN.
- Defined: opcode 0010111 (AUIPC) decodes to op_a=i_pc, op_b={instr[31:12],12'b0}, alu_op=ADD.
- Undefined: AUIPC is illegal per REQ-025.

Verification
REQ-031 Bench SHALL check: i_instr=0x002081B3, rs1=5, rs2=7, i_iss_rdy=1 -> next cycle o_op_a=5, o_op_b=7, o_alu_op=0, o_rd_addr=3, o_rd_wen=1, o_iss_cnt=1 after accept.
REQ-032 Bench SHALL check: 0x402081B3, rs1=5, rs2=7 -> o_alu_op=1; then 0x40335293 (SRAI x5,x6,3), rs1=0x80000000 -> o_op_b=3, o_alu_op=9, o_rd_addr=5.
REQ-033 Bench SHALL check: 0x123450B7 -> o_op_a=0, o_op_b=0x12345000, o_alu_op=A; 0x12345037 (rd=0) -> o_rd_wen=0.
REQ-034 Bench SHALL check: i_iss_rdy=0 for 3 cycles with i_instr_vld=1 -> outputs frozen, o_instr_rdy=0, o_iss_cnt unchanged; back-to-back stream with i_iss_rdy=1 -> one issue per cycle.
REQ-035 Bench SHALL check: 0x00001117 with i_pc=0x100 -> with ALU_ISSUE_AUIPC_EN, o_op_a=0x100, o_op_b=0x1000, o_alu_op=0; without it, o_illegal=1, o_rd_wen=0.
REQ-036 Bench SHALL check: i_rst_n pulsed low while o_iss_vld=1 and i_iss_rdy=0 -> all outputs 0 immediately, and the held instruction is never issued.
